// File: rtl/bcp_axil_pkg.sv
// Shared constants and the byte-strobe merge helper for the BCP AXI4-Lite register slave.
package bcp_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         ADDR_LSB    = 2;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcp_axil_hold.sv
// Single-entry holding register: captures a channel beat on load, drops it on clear.
module bcp_axil_hold #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         clr_i,
    input  logic [W-1:0] data_i,
    output logic         full_o,
    output logic [W-1:0] data_o
);

    logic         full_q;
    logic [W-1:0] data_q;

    // Entry state: clear wins over load so a commit always empties the entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (clr_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            full_q <= 1'b1;
            data_q <= data_i;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/bcp_axil_reg_slave.sv
// AXI4-Lite register slave for the BCP control plane: RW control regs below, RO status on top.
// Define BCP_AXIL_SLVERR_EN to answer out-of-range and RO-write accesses with SLVERR.
module bcp_axil_reg_slave
    import bcp_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int NUM_REGS           = 16,
    parameter int NUM_RO             = 4,
    localparam int NUM_RW            = NUM_REGS - NUM_RO,
    localparam int ST_W              = ((NUM_RO > 0) ? NUM_RO : 1) * 32
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [NUM_RW*32-1:0]              ctrl_q,
    output logic [NUM_RW-1:0]                 ctrl_wr_pulse,
    input  logic [ST_W-1:0]                   status_i
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int HI_W  = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
    localparam int WH_W  = C_S_AXI_DATA_WIDTH + C_S_AXI_DATA_WIDTH / 8;

    logic                          rst_done_q;
    logic                          aw_full_s, w_full_s;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_data_s, wr_addr_s;
    logic [WH_W-1:0]               w_data_s, w_in_s;
    logic [31:0]                   wr_data_s;
    logic [3:0]                    wr_strb_s;
    logic                          aw_hs_s, w_hs_s, ar_hs_s, commit_s;
    logic [IDX_W-1:0]              wr_idx_s, rd_idx_s;
    logic                          wr_inrange_s, wr_rw_s, rd_inrange_s;
    logic [1:0]                    wr_resp_s, rd_resp_s;
    logic [31:0]                   rd_data_s;
    logic [31:0]                   regs_view_s [NUM_REGS];
    logic [31:0]                   ctrl_mem_q [NUM_RW];
    logic [NUM_RW-1:0]             pulse_q;
    logic                          bvalid_q, rvalid_q;
    logic [1:0]                    bresp_q, rresp_q;
    logic [31:0]                   rdata_q;
    logic                          unused_s;

    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr_s[1:0], S_AXI_ARADDR[1:0]};

    // Readies stay low through reset and rise on the first edge after release.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rst_done_q <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
        end
    end

    assign S_AXI_AWREADY = rst_done_q && !aw_full_s && !bvalid_q;
    assign S_AXI_WREADY  = rst_done_q && !w_full_s && !bvalid_q;
    assign S_AXI_ARREADY = rst_done_q && !rvalid_q;
    assign aw_hs_s       = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs_s        = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs_s       = S_AXI_ARVALID && S_AXI_ARREADY;
    // A beat arriving on the completing handshake bypasses its holding entry.
    assign commit_s      = (aw_full_s || aw_hs_s) && (w_full_s || w_hs_s) && !bvalid_q;
    assign w_in_s        = {S_AXI_WSTRB, S_AXI_WDATA};

    bcp_axil_hold #(.W(C_S_AXI_ADDR_WIDTH)) u_aw_hold (
        .clk_i  (S_AXI_ACLK),
        .rst_ni (S_AXI_ARESETN),
        .load_i (aw_hs_s && !commit_s),
        .clr_i  (commit_s),
        .data_i (S_AXI_AWADDR),
        .full_o (aw_full_s),
        .data_o (aw_data_s)
    );

    bcp_axil_hold #(.W(WH_W)) u_w_hold (
        .clk_i  (S_AXI_ACLK),
        .rst_ni (S_AXI_ARESETN),
        .load_i (w_hs_s && !commit_s),
        .clr_i  (commit_s),
        .data_i (w_in_s),
        .full_o (w_full_s),
        .data_o (w_data_s)
    );

    assign wr_addr_s              = aw_full_s ? aw_data_s : S_AXI_AWADDR;
    assign {wr_strb_s, wr_data_s} = w_full_s ? w_data_s : w_in_s;
    assign wr_idx_s               = wr_addr_s[ADDR_LSB +: IDX_W];
    assign rd_idx_s               = S_AXI_ARADDR[ADDR_LSB +: IDX_W];
    assign wr_inrange_s = wr_addr_s[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB] < HI_W'(NUM_REGS);
    assign rd_inrange_s = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB] < HI_W'(NUM_REGS);
    assign wr_rw_s      = wr_inrange_s && (int'(wr_idx_s) < NUM_RW);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_view
        if (g < NUM_RW) begin : g_rw
            assign regs_view_s[g]      = ctrl_mem_q[g];
            assign ctrl_q[32*g +: 32]  = ctrl_mem_q[g];
        end else begin : g_ro
            assign regs_view_s[g] = status_i[32*(g-NUM_RW) +: 32];
        end
    end

    // Read data selection and response codes for both channels.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        wr_resp_s = RESP_OKAY;
        rd_resp_s = RESP_OKAY;
        if (rd_inrange_s) begin
            rd_data_s = regs_view_s[rd_idx_s];
        end else begin
            rd_data_s = 32'h0000_0000;
        end
`ifdef BCP_AXIL_SLVERR_EN
        if (!wr_rw_s) begin
            wr_resp_s = RESP_SLVERR;
        end else begin
            wr_resp_s = RESP_OKAY;
        end
        if (!rd_inrange_s) begin
            rd_resp_s = RESP_SLVERR;
        end else begin
            rd_resp_s = RESP_OKAY;
        end
`endif
    end

    // RW register array with per-register write pulse on commit.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < NUM_RW; i++) begin
                ctrl_mem_q[i] <= 32'h0000_0000;
            end
            pulse_q <= '0;
        end else begin
            pulse_q <= '0;
            for (int i = 0; i < NUM_RW; i++) begin
                if (commit_s && wr_rw_s && (int'(wr_idx_s) == i)) begin
                    ctrl_mem_q[i] <= strb_merge(ctrl_mem_q[i], wr_data_s, wr_strb_s);
                    pulse_q[i]    <= 1'b1;
                end
            end
        end
    end

    // Write response channel.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (commit_s) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_resp_s;
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end
    end

    // Read data channel: one cycle from AR handshake to RVALID.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= 32'h0000_0000;
        end else if (ar_hs_s) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_resp_s;
            rdata_q  <= rd_data_s;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    assign ctrl_wr_pulse = pulse_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

endmodule
